// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if -- pin and result bundle for the PS/2 frame receiver.
//   kb_clk, kb_data : raw PS/2 pins (asynchronous to the system clock)
//   scan_code       : last good byte
//   code_valid      : one-cycle strobe, scan_code updated
//   frame_err       : one-cycle strobe on parity/stop/timeout error
//   rx_busy         : frame in progress
// master = keyboard/host side, slave = the receiver.
interface ps2_frame_rx_if;
    logic       kb_clk;
    logic       kb_data;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output kb_clk, kb_data,
        input  scan_code, code_valid, frame_err, rx_busy
    );

    modport slave (
        input  kb_clk, kb_data,
        output scan_code, code_valid, frame_err, rx_busy
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx -- PS/2 keyboard frame receiver.
// Synchronises kb_clk/kb_data, detects kb_clk falls and deserialises
// 11-bit frames (start, 8 data LSB first, odd parity, stop).
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ps2_frame_rx_if.slave (pins in, scan_code/code_valid/
//          frame_err/rx_busy out, all registered)
module ps2_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 100000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_frame_rx_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RECV} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   kb_prev;
    logic                   kb_sync, dat, fall;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic [8:0]  shreg, shreg_n;        // {parity, data[7:0]} once full
    logic [7:0]  code, code_n;
    logic        valid, valid_n;
    logic        err, err_n;

    // Pin synchronisers; reset to 1 so the bus looks idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            kb_prev  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.kb_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.kb_data};
            kb_prev  <= kb_sync;
        end
    end

    assign kb_sync = clk_sync[SYNC_STAGES-1];
    assign dat     = dat_sync[SYNC_STAGES-1];
    assign fall    = kb_prev & ~kb_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            shreg   <= '0;
            code    <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            tmo_cnt <= tmo_cnt_n;
            shreg   <= shreg_n;
            code    <= code_n;
            valid   <= valid_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        tmo_cnt_n = tmo_cnt;
        shreg_n   = shreg;
        code_n    = code;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                // A fall with data high is not a start bit: ignore it.
                if (fall && !dat) begin
                    state_n   = RECV;
                    bit_cnt_n = '0;
                    tmo_cnt_n = '0;
                end
            end
            RECV: begin
                // A fall wins over a timeout reached in the same cycle.
                if (fall) begin
                    tmo_cnt_n = '0;
                    if (bit_cnt == 4'd9) begin
                        state_n = IDLE;
                        // Odd parity over data+parity, stop must be 1.
                        if ((^shreg) && dat) begin
                            code_n  = shreg[7:0];
                            valid_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        shreg_n   = {dat, shreg[8:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else if (tmo_cnt == TW'(TIMEOUT)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.scan_code  = code;
    assign bus.code_valid = valid;
    assign bus.frame_err  = err;
    assign bus.rx_busy    = (state == RECV);
endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 keyboard frame receiver: synchronises the raw `kb_clk`/`kb_data` pins to `clk` and detects `kb_clk` falling edges. It deserialises 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and emits each checked scan code as a one-cycle `code_valid` strobe. It is the first stage inside `keyboard_top`, feeding the scan-code/make-break handling that drives `sc`, `num` and `seg_en`.

## Interface
- `SYNC_STAGES`, 2: flip-flops in each pin synchroniser, ≥2.
- `TIMEOUT`, 100000: `clk` cycles without a `kb_clk` fall inside a frame before the frame is aborted (1 ms at 100 MHz).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `kb_clk` in 1: raw PS/2 clock pin, asynchronous.
- `kb_data` in 1: raw PS/2 data pin, asynchronous.
- `scan_code` out 8: last correctly received byte, held until the next good frame.
- `code_valid` out 1: one-cycle strobe, `scan_code` updated this cycle.
- `frame_err` out 1: one-cycle strobe on a parity, stop-bit or timeout error.
- `rx_busy` out 1: high while a frame is in progress (state RECV).

## Operation
- **Synchronisers:** `SYNC_STAGES`-deep chains on both pins, reset value 1 (bus idle). `kb_prev` registers the synchronised clock. `fall = kb_prev & ~kb_sync`, one cycle per PS/2 clock fall.
- **State IDLE:**
  - `fall` with synchronised data 0 (start bit): go to RECV, bit count 0, timeout counter 0.
  - `fall` with data 1: ignored. No error, stays IDLE.
- **State RECV:**
  - Each `fall` shifts the sampled data bit in and increments the bit count 0..9. Bits 0-7 are data (LSB first), bit 8 is parity, bit 9 is stop.
  - When the stop bit is sampled, return to IDLE:
    - Good frame: XOR of the 8 data bits and parity is 1, and stop is 1. Load `scan_code` with the data and pulse `code_valid`.
    - Otherwise pulse `frame_err`; `scan_code` is unchanged.
- **Timeout:**
  - In RECV the counter increments every cycle and clears on each `fall`.
  - At `TIMEOUT` with no `fall`: pulse `frame_err`, discard the partial frame, go to IDLE.
  - A `fall` in the same cycle the counter reaches `TIMEOUT` wins: the bit is taken and there is no error.
- **Exclusivity:** `code_valid` and `frame_err` are never high in the same cycle. Neither is ever high for two consecutive cycles.
- **Reset mid-frame:** the partial frame is discarded with no strobe; the state returns to IDLE.
- **Widths:** the bit counter is 4 bits. The timeout counter is wide enough to hold `TIMEOUT` (17 bits for the default) and saturates and does not wrap.

## Timing
- **Reset values:**
  - `scan_code` = 0x00; `code_valid`, `frame_err`, `rx_busy` = 0.
  - State IDLE; synchronisers and `kb_prev` = 1.
- **Latency:**
  - Let E0 be the first rising `clk` edge that samples the stop-bit `kb_clk` fall low.
  - With `SYNC_STAGES`=2, `code_valid`/`frame_err` is high for exactly the cycle following edge E2.
  - Each extra synchroniser stage adds one cycle.
- **`rx_busy` timing:** high from the cycle after the start-bit `fall` is consumed; low in the same cycle the `code_valid`/`frame_err` strobe is high.
- **Supported PS/2 clock:** half-period ≥ `SYNC_STAGES`+2 `clk` cycles. Back-to-back frames need no idle gap beyond one PS/2 clock period.
- **Outputs:** all outputs are registered, with no combinational path from the pins.

## Test plan
All scenarios use `TIMEOUT`=64 and a PS/2 clock half-period of 20 `clk` cycles.
- **Single frame:** after reset, send 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1). Expect `scan_code`=0x1C, one `code_valid` pulse 3 cycles after the stop-bit fall, `frame_err` never high, `rx_busy` low afterwards.
- **Break sequence:** send 0xF0 (parity 1) then 0x1C back-to-back. Expect two `code_valid` pulses; `scan_code` reads 0xF0 then 0x1C.
- **Parity and stop errors:**
  - After a good 0x1C, send 0x29 with parity 1 (wrong). Expect one `frame_err` pulse, no `code_valid`, `scan_code` stays 0x1C.
  - Repeat with stop bit 0. Same response.
- **Timeout:** send start plus 4 data bits, then hold `kb_clk` high for 70 cycles. Expect `frame_err` pulse once the count hits 64 and `rx_busy` dropping. A following good 0x29 (parity 0) then gives `scan_code`=0x29 with `code_valid`.
- **Reset and false start:**
  - Assert `rst` for 1 cycle after 5 bits of a frame. Expect all outputs 0 and no strobe; the next 0x1C frame is received correctly.
  - A `kb_clk` fall with `kb_data`=1 while idle produces no strobe and `rx_busy` stays 0.
